// File: rtl/bday_scroll.sv
// ============================================================================
// bday_scroll : seven-segment message scroller with loop/one-shot modes
// Rev 1.0
// ============================================================================
`default_nettype none

module bday_scroll #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           pause,
  input  logic                           mode,
  input  logic                           msg_we,
  input  logic [$clog2(MSG_LEN)-1:0]     msg_waddr,
  input  logic [4:0]                     msg_wdata,
  output logic [NUM_DIGITS-1:0][6:0]     led,
  output logic                           busy,
  output logic                           done
);

  localparam int c_AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int c_DW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_mode;
  logic [c_AW-1:0]     r_offset;
  logic [c_DW-1:0]     r_div;
  logic [4:0]          r_msg [MSG_LEN];

  logic [NUM_DIGITS-1:0][6:0] w_win;
  logic                       w_div_wrap;

  function automatic logic [6:0] f_seg(input logic [4:0] code);
    case (code)
      5'h00: f_seg = 7'h3F;  5'h01: f_seg = 7'h06;
      5'h02: f_seg = 7'h5B;  5'h03: f_seg = 7'h4F;
      5'h04: f_seg = 7'h66;  5'h05: f_seg = 7'h6D;
      5'h06: f_seg = 7'h7D;  5'h07: f_seg = 7'h07;
      5'h08: f_seg = 7'h7F;  5'h09: f_seg = 7'h6F;
      5'h0A: f_seg = 7'h77;  5'h0B: f_seg = 7'h7C;
      5'h0C: f_seg = 7'h39;  5'h0D: f_seg = 7'h5E;
      5'h0E: f_seg = 7'h79;  5'h0F: f_seg = 7'h71;
      5'h11: f_seg = 7'h40;
      default: f_seg = 7'h00;
    endcase
  endfunction

  // Leftmost digit (highest index) shows the character at the current offset.
  always_comb begin
    w_win = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      int idx;
      idx = int'(r_offset) + NUM_DIGITS - 1 - i;
      if (idx >= MSG_LEN) idx = idx - MSG_LEN;
      w_win[i] = f_seg(r_msg[c_AW'(idx)]);
    end
  end

  assign w_div_wrap = (r_div == c_DW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_offset <= '0;
      r_div    <= '0;
      for (int i = 0; i < MSG_LEN; i++) r_msg[i] <= 5'h10;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      led  <= (r_state == S_IDLE) ? '0 : w_win;
      busy <= (r_state == S_RUN);
      done <= (r_state == S_DONE);

      case (r_state)
        S_IDLE: begin
          if (msg_we && (int'(msg_waddr) < MSG_LEN))
            r_msg[msg_waddr] <= msg_wdata;
          if (start && !stop) begin
            r_state  <= S_RUN;
            r_mode   <= mode;
            r_offset <= '0;
            r_div    <= '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state  <= S_IDLE;
            r_offset <= '0;
            r_div    <= '0;
          end else if (!pause) begin
            r_div <= w_div_wrap ? '0 : r_div + c_DW'(1);
            if (w_div_wrap) begin
              // One-shot ends on the tick after the final window is reached.
              if (r_mode && (r_offset == c_AW'(MSG_LEN - NUM_DIGITS)))
                r_state <= S_DONE;
              else if (r_offset == c_AW'(MSG_LEN - 1))
                r_offset <= '0;
              else
                r_offset <= r_offset + c_AW'(1);
            end
          end
        end
        S_DONE: begin
          if (stop) begin
            r_state  <= S_IDLE;
            r_offset <= '0;
          end else if (start) begin
            r_state  <= S_RUN;
            r_mode   <= mode;
            r_offset <= '0;
            r_div    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bday_scroll.sv
// ============================================================================
// tb_bday_scroll : directed + random check of bday_scroll against a time-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bday_scroll;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst, start, stop, pause, mode, msg_we;
  logic [2:0] msg_waddr;
  logic [4:0] msg_wdata;
  logic [ND-1:0][6:0] led;
  logic busy, done;

  always #5 clk = ~clk;

  bday_scroll #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .msg_we(msg_we), .msg_waddr(msg_waddr), .msg_wdata(msg_wdata),
    .led(led), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase 0=idle 1=run 2=done; position derived from unpaused run cycles.
  logic [4:0] ref_msg [ML];
  int m_phase;
  int m_elapsed;
  bit m_one;

  function automatic logic [6:0] seg(input logic [4:0] c);
    case (c)
      5'h00: return 7'h3F; 5'h01: return 7'h06; 5'h02: return 7'h5B; 5'h03: return 7'h4F;
      5'h04: return 7'h66; 5'h05: return 7'h6D; 5'h06: return 7'h7D; 5'h07: return 7'h07;
      5'h08: return 7'h7F; 5'h09: return 7'h6F; 5'h0A: return 7'h77; 5'h0B: return 7'h7C;
      5'h0C: return 7'h39; 5'h0D: return 7'h5E; 5'h0E: return 7'h79; 5'h0F: return 7'h71;
      5'h11: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int m_off();
    int steps;
    steps = m_elapsed / TD;
    if (m_one) return (steps > ML - ND) ? ML - ND : steps;
    return steps % ML;
  endfunction

  function automatic logic [ND-1:0][6:0] m_view();
    logic [ND-1:0][6:0] v;
    v = '0;
    if (m_phase != 0)
      for (int i = 0; i < ND; i++) v[i] = seg(ref_msg[(m_off() + ND - 1 - i) % ML]);
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ML; i++) ref_msg[i] = 5'h10;
    m_phase = 0; m_elapsed = 0; m_one = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit s, input bit sp, input bit p, input bit md,
                      input bit we, input int a, input int d);
    logic [ND-1:0][6:0] e_led;
    logic e_busy, e_done;
    start = s; stop = sp; pause = p; mode = md;
    msg_we = we; msg_waddr = 3'(a); msg_wdata = 5'(d);
    e_led  = m_view();
    e_busy = (m_phase == 1);
    e_done = (m_phase == 2);
    case (m_phase)
      0: begin
        if (we) ref_msg[a] = 5'(d);
        if (s && !sp) begin m_phase = 1; m_elapsed = 0; m_one = md; end
      end
      1: begin
        if (sp) m_phase = 0;
        else if (!p) begin
          m_elapsed++;
          if (m_one && (m_elapsed / TD > ML - ND)) m_phase = 2;
        end
      end
      default: begin
        if (sp) m_phase = 0;
        else if (s) begin m_phase = 1; m_elapsed = 0; m_one = md; end
      end
    endcase
    @(posedge clk);
    #1;
    chk("led", 32'(led), 32'(e_led));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [4:0] load [8];
    logic [27:0] held;
    load = '{5'h01, 5'h02, 5'h00, 5'h03, 5'h11, 5'h02, 5'h00, 5'h02};
    rst = 1'b1; start = 0; stop = 0; pause = 0; mode = 0;
    msg_we = 0; msg_waddr = '0; msg_wdata = '0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Blank buffer run
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("blank_run", 32'(led), 32'h0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);

    // Load buffer and loop
    for (int i = 0; i < ML; i++) step(0, 0, 0, 0, 1, i, int'(load[i]));
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("win0", 32'(led), 32'({7'h06, 7'h5B, 7'h3F, 7'h4F}));
    idle(4);
    chk("win1", 32'(led), 32'({7'h5B, 7'h3F, 7'h4F, 7'h40}));
    idle(28);
    chk("wrap_win0", 32'(led), 32'({7'h06, 7'h5B, 7'h3F, 7'h4F}));
    chk("wrap_busy", 32'(busy), 32'h1);
    step(0, 1, 0, 0, 0, 0, 0);

    // One-shot
    step(1, 0, 0, 1, 0, 0, 0);
    idle(17);
    chk("last_win", 32'(led), 32'({7'h40, 7'h5B, 7'h3F, 7'h5B}));
    idle(4);
    chk("os_done", 32'(done), 32'h1);
    chk("os_busy", 32'(busy), 32'h0);
    held = led;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 1, 0, 7);
    chk("os_hold", 32'(led), 32'(held));
    step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    chk("restart_win0", 32'(led), 32'({7'h06, 7'h5B, 7'h3F, 7'h4F}));

    // Pause mid-run (loop mode, two cycles into a step)
    idle(1);
    held = led;
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 0, 0);
    chk("pause_hold", 32'(led), 32'(held));
    idle(6);

    // start+stop in idle; stop on a tick cycle
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(2);
    chk("startstop_idle", 32'(busy), 32'h0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    chk("stop_tick_led", 32'(led), 32'h0);

    // Write during run ignored, then async reset mid-run
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 5'h08);
    idle(2);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("async_led", 32'(led), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    #2 rst = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    chk("post_reset_blank", 32'(led), 32'h0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 10) == 0, ($urandom % 24) == 0, ($urandom % 5) == 0,
           1'($urandom), ($urandom % 3) == 0, int'($urandom % ML), int'($urandom % 32));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
